// File: rtl/mult_arb_pkg.sv
// Shared types and round-robin helper for the multiplier-sharing arbiter.
package mult_arb_pkg;

   typedef enum logic [1:0] {IDLE, ISSUE, WAIT, RESP} arbState_t;

   localparam int unsigned MaxReq  = 8;
   localparam int unsigned MaxIdxW = 3;

   // First valid index at or after ptr, searching upward modulo numReq; returns ptr if none valid.
   function automatic int unsigned rrNext(input logic [MaxReq-1:0] valid,
                                          input int unsigned       ptr,
                                          input int unsigned       numReq);
      int unsigned idx;
      logic        found;
      rrNext = ptr;
      found  = 1'b0;
      for (int unsigned k = 0; k < MaxReq; k++) begin
         idx = ptr + k;
         if (idx >= numReq) idx = idx - numReq;
         if (!found && (k < numReq) && valid[idx[MaxIdxW-1:0]]) begin
            found  = 1'b1;
            rrNext = idx;
         end
      end
   endfunction

endpackage

// File: rtl/mult_share_arbiter_rr_grant.sv
// Purely combinational round-robin grant: one-hot grant plus encoded index.
module rr_grant
   import mult_arb_pkg::*;
#(
   parameter int unsigned NUM_REQ = 3,
   parameter int unsigned ID_W    = 2
) (
   input  logic [NUM_REQ-1:0] reqValid,
   input  logic [ID_W-1:0]    rrPtr,
   output logic [NUM_REQ-1:0] grant_c,
   output logic [ID_W-1:0]    grantIdx_c
);

   int unsigned sel;

   always_comb begin
      sel        = rrNext(MaxReq'(reqValid), 32'(rrPtr), NUM_REQ);
      grantIdx_c = ID_W'(sel);
      grant_c    = '0;
      if (|reqValid) grant_c = NUM_REQ'(1) << sel;
   end

endmodule

// File: rtl/mult_share_arbiter.sv
// Round-robin sharing of one sequential multiplier among NUM_REQ requesters.
// Optional constant-latency response enabled by defining MULT_ARB_FIXED_LAT_EN.
module mult_share_arbiter
   import mult_arb_pkg::*;
#(
   parameter int unsigned WIDTH   = 4,
   parameter int unsigned NUM_REQ = 3,
   parameter int unsigned ID_W    = 2
`ifdef MULT_ARB_FIXED_LAT_EN
   ,
   parameter int unsigned FIXED_LAT = 8
`endif
) (
   input  logic                     clk,
   input  logic                     rst,
   input  logic [NUM_REQ-1:0]       req_valid,
   output logic [NUM_REQ-1:0]       req_ready,
   input  logic [NUM_REQ*WIDTH-1:0] req_multiplier,
   input  logic [NUM_REQ*WIDTH-1:0] req_multiplicand,
   output logic                     mult_start,
   output logic [WIDTH-1:0]         mult_multiplier,
   output logic [WIDTH-1:0]         mult_multiplicand,
   input  logic [2*WIDTH-1:0]       mult_product,
   input  logic                     mult_done,
   output logic                     rsp_valid,
   input  logic                     rsp_ready,
   output logic [ID_W-1:0]          rsp_id,
   output logic [2*WIDTH-1:0]       rsp_product,
   output logic                     busy
`ifdef MULT_ARB_FIXED_LAT_EN
   ,
   output logic                     lat_overrun
`endif
);

   arbState_t          state, stateNext;
   logic [ID_W-1:0]    rrPtr;
   logic [ID_W-1:0]    grantIdx;
   logic [NUM_REQ-1:0] grant;
   logic               handshake;
   logic               captureEn;
   logic               leaveWait;

`ifdef MULT_ARB_FIXED_LAT_EN
   localparam int unsigned LatW = $clog2(FIXED_LAT + 2) + 1;
   localparam logic [LatW-1:0] LatTarget = LatW'(FIXED_LAT);
   localparam logic [LatW-1:0] LatMax    = LatW'(FIXED_LAT + 1);

   logic [LatW-1:0] latCnt;
   logic            captured;
`endif

   rr_grant #(
      .NUM_REQ (NUM_REQ),
      .ID_W    (ID_W)
   ) u_rrGrant (
      .reqValid   (req_valid),
      .rrPtr      (rrPtr),
      .grant_c    (grant),
      .grantIdx_c (grantIdx)
   );

   // Grants are offered only while idle, so at most one job is ever in flight.
   assign req_ready = (state == IDLE) ? grant : '0;
   assign handshake = |(req_valid & req_ready);

   always_comb begin
      stateNext = state;
      captureEn = 1'b0;
      leaveWait = 1'b0;
      unique case (state)
         IDLE:  if (handshake) stateNext = ISSUE;
         ISSUE: stateNext = WAIT;
         WAIT: begin
`ifdef MULT_ARB_FIXED_LAT_EN
            captureEn = mult_done && !captured;
            leaveWait = (captured || mult_done) && (latCnt >= LatTarget);
`else
            captureEn = mult_done;
            leaveWait = mult_done;
`endif
            if (leaveWait) stateNext = RESP;
         end
         RESP:    if (rsp_ready) stateNext = IDLE;
         default: stateNext = IDLE;
      endcase
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         state             <= IDLE;
         rrPtr             <= '0;
         mult_start        <= 1'b0;
         mult_multiplier   <= '0;
         mult_multiplicand <= '0;
         rsp_valid         <= 1'b0;
         rsp_id            <= '0;
         rsp_product       <= '0;
         busy              <= 1'b0;
      end else begin
         state      <= stateNext;
         mult_start <= (stateNext == ISSUE);
         rsp_valid  <= (stateNext == RESP);
         busy       <= (stateNext != IDLE);
         if (handshake) begin
            mult_multiplier   <= req_multiplier[32'(grantIdx) * WIDTH +: WIDTH];
            mult_multiplicand <= req_multiplicand[32'(grantIdx) * WIDTH +: WIDTH];
            rsp_id            <= grantIdx;
            rrPtr             <= (grantIdx == ID_W'(NUM_REQ - 1)) ? '0 : grantIdx + ID_W'(1);
         end
         if (captureEn) rsp_product <= mult_product;
      end
   end

`ifdef MULT_ARB_FIXED_LAT_EN
   // Cycle counter from the start pulse; saturates once past the target so overrun stays visible.
   always_ff @(posedge clk) begin
      if (rst) begin
         latCnt      <= '0;
         captured    <= 1'b0;
         lat_overrun <= 1'b0;
      end else begin
         lat_overrun <= captureEn && (latCnt > LatTarget);
         if (stateNext == ISSUE) begin
            latCnt   <= '0;
            captured <= 1'b0;
         end else begin
            if (((state == ISSUE) || (state == WAIT)) && (latCnt != LatMax))
               latCnt <= latCnt + LatW'(1);
            if (captureEn) captured <= 1'b1;
         end
      end
   end
`endif

endmodule

// File: tb/tb_mult_share_arbiter.sv
// Scoreboard bench for mult_share_arbiter with a mock sequential multiplier.
module tb_mult_share_arbiter;

   localparam int FixedLat = 8;

   typedef struct packed {
      logic [1:0] id;
      logic [7:0] prod;
   } expRsp_t;

   logic        clk = 1'b0;
   logic        rst = 1'b1;
   logic [2:0]  req_valid = '0;
   logic [2:0]  req_ready;
   logic [11:0] req_multiplier = '0;
   logic [11:0] req_multiplicand = '0;
   logic        mult_start;
   logic [3:0]  mult_multiplier;
   logic [3:0]  mult_multiplicand;
   logic [7:0]  mult_product = '0;
   logic        mult_done = 1'b0;
   logic        rsp_valid;
   logic        rsp_ready = 1'b0;
   logic [1:0]  rsp_id;
   logic [7:0]  rsp_product;
   logic        busy;
`ifdef MULT_ARB_FIXED_LAT_EN
   logic        lat_overrun;
`endif

   expRsp_t sbQ[$];
   int      chkCnt = 0;
   int      errCnt = 0;
   int      rrModel = 0;
   int      doneDelay = 4;
   bit      forceIssueDone = 1'b0;
   int      remCnt = 0;
   int      startCnt = 0;
   int      ovCnt = 0;

   mult_share_arbiter dut (
      .clk               (clk),
      .rst               (rst),
      .req_valid         (req_valid),
      .req_ready         (req_ready),
      .req_multiplier    (req_multiplier),
      .req_multiplicand  (req_multiplicand),
      .mult_start        (mult_start),
      .mult_multiplier   (mult_multiplier),
      .mult_multiplicand (mult_multiplicand),
      .mult_product      (mult_product),
      .mult_done         (mult_done),
      .rsp_valid         (rsp_valid),
      .rsp_ready         (rsp_ready),
      .rsp_id            (rsp_id),
      .rsp_product       (rsp_product),
      .busy              (busy)
`ifdef MULT_ARB_FIXED_LAT_EN
      ,
      .lat_overrun       (lat_overrun)
`endif
   );

   always #5 clk = ~clk;

   // Mock multiplier: done pulses doneDelay cycles after the start cycle.
   always @(negedge clk) begin
      mult_done = 1'b0;
      if (remCnt > 0) begin
         remCnt--;
         if (remCnt == 0) begin
            mult_done    = 1'b1;
            mult_product = 8'(mult_multiplier) * 8'(mult_multiplicand);
         end
      end
      if (mult_start) begin
         startCnt++;
         remCnt = doneDelay;
         if (forceIssueDone) begin
            mult_done    = 1'b1;
            mult_product = 8'hEE;
         end
      end
`ifdef MULT_ARB_FIXED_LAT_EN
      if (lat_overrun) ovCnt++;
`endif
   end

   task automatic checkEq(input string tag, input logic [31:0] got, input logic [31:0] exp);
      chkCnt++;
      if (got !== exp) begin
         errCnt++;
         $display("FAIL %s: got %0d expected %0d", tag, got, exp);
      end
   endtask

   function automatic int modelGrant(input logic [2:0] v, input int p);
      for (int k = 0; k < 3; k++) begin
         if (v[2'((p + k) % 3)]) return (p + k) % 3;
      end
      return -1;
   endfunction

   function automatic int expLat(input int d);
`ifdef MULT_ARB_FIXED_LAT_EN
      return ((d <= FixedLat) ? FixedLat : d) + 2;
`else
      return d + 2;
`endif
   endfunction

   task automatic checkZero(input string tag);
      checkEq({tag, "_mult_start"}, 32'(mult_start), 0);
      checkEq({tag, "_mult_a"}, 32'(mult_multiplier), 0);
      checkEq({tag, "_mult_b"}, 32'(mult_multiplicand), 0);
      checkEq({tag, "_rsp_valid"}, 32'(rsp_valid), 0);
      checkEq({tag, "_rsp_id"}, 32'(rsp_id), 0);
      checkEq({tag, "_rsp_product"}, 32'(rsp_product), 0);
      checkEq({tag, "_busy"}, 32'(busy), 0);
      checkEq({tag, "_req_ready"}, 32'(req_ready), 0);
`ifdef MULT_ARB_FIXED_LAT_EN
      checkEq({tag, "_lat_overrun"}, 32'(lat_overrun), 0);
`endif
   endtask

   // Called at posedge+1; returns at posedge+1 of the ISSUE cycle.
   task automatic waitGrant(input bit keepValid, output int g);
      int         e;
      logic [3:0] a, b;
      g = -1;
      for (int c = 0; c < 20 && g < 0; c++) begin
         #1;
         e = modelGrant(req_valid, rrModel);
         checkEq("req_ready", 32'(req_ready), (e < 0) ? 32'd0 : (32'd1 << e));
         if (e >= 0) g = e;
         @(posedge clk); #1;
      end
      if (g < 0) begin
         checkEq("grant_timeout", 0, 1);
         return;
      end
      a = 4'(req_multiplier >> (4 * g));
      b = 4'(req_multiplicand >> (4 * g));
      sbQ.push_back('{id: 2'(g), prod: 8'(a) * 8'(b)});
      rrModel = (g + 1) % 3;
      if (!keepValid) req_valid[2'(g)] = 1'b0;
      checkEq("issue_start", 32'(mult_start), 1);
      checkEq("issue_a", 32'(mult_multiplier), 32'(a));
      checkEq("issue_b", 32'(mult_multiplicand), 32'(b));
      checkEq("issue_ready", 32'(req_ready), 0);
      checkEq("issue_busy", 32'(busy), 1);
   endtask

   task automatic finishJob(input int d, input int hold, input bit rdyEarly);
      int      lat, st0, ov0;
      expRsp_t exp;
      st0 = startCnt;
      ov0 = ovCnt;
      if (rdyEarly) rsp_ready = 1'b1;
      lat = 1;
      while (!rsp_valid && lat < 40) begin
         @(posedge clk); #1;
         lat++;
      end
      checkEq("latency", 32'(lat), 32'(expLat(d)));
      if (sbQ.size() == 0) begin
         checkEq("scoreboard_empty", 0, 1);
         return;
      end
      exp = sbQ[0];
      for (int h = 0; h < hold; h++) begin
         checkEq("hold_valid", 32'(rsp_valid), 1);
         checkEq("hold_product", 32'(rsp_product), 32'(exp.prod));
         checkEq("hold_id", 32'(rsp_id), 32'(exp.id));
         checkEq("hold_ready", 32'(req_ready), 0);
         @(posedge clk); #1;
      end
      rsp_ready = 1'b1;
      exp = sbQ.pop_front();
      checkEq("rsp_valid", 32'(rsp_valid), 1);
      checkEq("rsp_id", 32'(rsp_id), 32'(exp.id));
      checkEq("rsp_product", 32'(rsp_product), 32'(exp.prod));
      checkEq("resp_req_ready", 32'(req_ready), 0);
      @(posedge clk); #1;
      rsp_ready = 1'b0;
      checkEq("rsp_accepted_once", 32'(rsp_valid), 0);
      checkEq("start_pulses", 32'(startCnt - st0), 1);
`ifdef MULT_ARB_FIXED_LAT_EN
      checkEq("lat_overrun_pulses", 32'(ovCnt - ov0), (d > FixedLat) ? 32'd1 : 32'd0);
`else
      checkEq("no_overrun_port", 32'(ovCnt - ov0), 0);
`endif
   endtask

   task automatic runJob(input bit keepValid, input int d, input int hold, input bit rdyEarly);
      int g;
      doneDelay = d;
      waitGrant(keepValid, g);
      if (g >= 0) finishJob(d, hold, rdyEarly);
   endtask

   initial begin
      #100000;
      $display("FAIL watchdog: simulation time limit reached, got timeout expected finish");
      $fatal(1, "watchdog");
   end

   initial begin
      bit sawAny;
      int g;
      repeat (2) @(posedge clk);
      #1;
      checkZero("reset");
      rst = 1'b0;

      // Single request from requester 0: 3 x 5, done 4 cycles after start.
      req_multiplier   = 12'h003;
      req_multiplicand = 12'h005;
      req_valid        = 3'b001;
      runJob(1'b0, 4, 0, 1'b0);

      // Restart pointer, then all three continuously valid with A=i+1, B=2.
      rst = 1'b1; @(posedge clk); #1; rst = 1'b0;
      rrModel          = 0;
      req_multiplier   = {4'd3, 4'd2, 4'd1};
      req_multiplicand = {4'd2, 4'd2, 4'd2};
      req_valid        = 3'b111;
      runJob(1'b1, 4, 0, 1'b1);
      runJob(1'b1, 2, 0, 1'b0);
      runJob(1'b1, 5, 0, 1'b1);
      runJob(1'b1, 3, 0, 1'b0);
      req_valid = 3'b000;

      // Response backpressure with 15 x 15.
      req_multiplier   = {4'd0, 4'd15, 4'd0};
      req_multiplicand = {4'd0, 4'd15, 4'd0};
      req_valid        = 3'b010;
      runJob(1'b0, 4, 5, 1'b0);

      // Done forced high in the start cycle must not be sampled.
      forceIssueDone   = 1'b1;
      req_multiplier   = {4'd0, 4'd0, 4'd6};
      req_multiplicand = {4'd0, 4'd0, 4'd3};
      req_valid        = 3'b001;
      runJob(1'b0, 4, 0, 1'b0);
      forceIssueDone = 1'b0;

      // Short and long multiplier times.
      req_multiplier   = {4'd9, 4'd0, 4'd0};
      req_multiplicand = {4'd4, 4'd0, 4'd0};
      req_valid        = 3'b100;
      runJob(1'b0, 3, 0, 1'b0);
      req_valid = 3'b100;
      runJob(1'b0, 10, 0, 1'b0);

      // Reset during WAIT: 7 x 7 aborted, late done ignored.
      req_multiplier   = {4'd0, 4'd0, 4'd7};
      req_multiplicand = {4'd0, 4'd0, 4'd7};
      req_valid        = 3'b001;
      doneDelay        = 10;
      waitGrant(1'b0, g);
      repeat (2) begin @(posedge clk); #1; end
      rst = 1'b1;
      @(posedge clk); #1;
      rst = 1'b0;
      sbQ.delete();
      rrModel = 0;
      checkZero("abort");
      sawAny = 1'b0;
      repeat (12) begin
         @(posedge clk); #1;
         if (rsp_valid || busy || (rsp_product != 8'd0)) sawAny = 1'b1;
      end
      checkEq("late_done_ignored", 32'(sawAny), 0);

      req_multiplier   = {4'd3, 4'd2, 4'd1};
      req_multiplicand = {4'd3, 4'd3, 4'd3};
      req_valid        = 3'b111;
      runJob(1'b0, 4, 0, 1'b0);
      req_valid = 3'b100;
      runJob(1'b0, 4, 0, 1'b0);

      $display("End of test - %0d assertions evaluated, %0d failures", chkCnt, errCnt);
      $finish;
   end

endmodule
